// File: rtl/pe_tg_pkg.sv
// Shared definitions for the traffic-generating PE: pattern codes, FSM
// encoding, flit field layout helpers and the injection LFSR.
package pe_tg_pkg;

   typedef enum logic [2:0] {
      PAT_RANDOM     = 3'd0,
      PAT_COMPLEMENT = 3'd1,
      PAT_REVERSE    = 3'd2,
      PAT_ROTATION   = 3'd3,
      PAT_TRANSPOSE  = 3'd4,
      PAT_TORNADO    = 3'd5,
      PAT_NEIGHBOUR  = 3'd6,
      PAT_NEIGHBOUR2 = 3'd7
   } pattern_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Flit layout: {head, tail, dest[AW-1:0], 1'b0, timestamp[DW-1:0]}
   function automatic int flit_width(input int dw, input int aw);
      return dw + aw + 3;
   endfunction

   function automatic int flit_dest_lsb(input int dw);
      return dw + 1;
   endfunction

   function automatic int flit_head_bit(input int dw, input int aw);
      return dw + aw + 2;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/pe_tg_dest.sv
// Combinational synthetic-pattern destination mapping. Results that land
// at or above NUM_PE are folded back once so they always name a real node.
module pe_tg_dest
   import pe_tg_pkg::*;
#(
   parameter int NUM_PE = 4,
   parameter int AW     = 2
) (
   input  pattern_e         pattern,
   input  logic [AW-1:0]    address,
   input  logic [AW-1:0]    rnd,
   output logic [AW-1:0]    dest
);

   localparam logic [AW:0] NPE         = (AW+1)'(NUM_PE);
   localparam logic [AW:0] TORNADO_OFF = (AW+1)'((NUM_PE + 1) / 2);

   logic [AW:0] raw;
   logic [AW:0] folded;

   function automatic logic [AW:0] fold(input logic [AW:0] v);
      return (v >= NPE) ? (v - NPE) : v;
   endfunction

   // Pattern selection; arithmetic patterns wrap modulo NUM_PE themselves
   always_comb begin
      raw = '0;
      case (pattern)
         PAT_RANDOM:     raw = {1'b0, rnd};
         PAT_COMPLEMENT: raw = {1'b0, ~address};
         PAT_REVERSE:    for (int j = 0; j < AW; j++) raw[j] = address[AW-1-j];
         PAT_ROTATION:   for (int j = 0; j < AW; j++) raw[j] = address[(j+1)%AW];
         PAT_TRANSPOSE:  for (int j = 0; j < AW; j++) raw[j] = address[(j+AW/2)%AW];
         PAT_TORNADO:    raw = fold({1'b0, address} + TORNADO_OFF);
         default:        raw = fold({1'b0, address} + (AW+1)'(1));
      endcase
      folded = fold(raw);
      dest   = folded[AW-1:0];
   end

endmodule

// File: rtl/pe_traffic_gen.sv
// Traffic-generating processing element: injects timestamped single-flit
// packets at a programmable rate and sinks incoming flits, accumulating
// count, error and latency statistics.
module pe_traffic_gen
   import pe_tg_pkg::*;
#(
   parameter int          ADDRESS   = 0,
   parameter int          NUM_PE    = 4,
   parameter int          AW        = 2,
   parameter int          DW        = 32,
   parameter int          PKT_LIMIT = 20,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [2:0]        i_pattern,
   input  logic [7:0]        i_rate,
   output logic [DW+AW+2:0]  o_data,
   output logic              o_data_valid,
   input  logic              i_data_ready,
   input  logic [DW+AW+2:0]  i_data,
   input  logic              i_data_valid,
   output logic              o_data_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic [31:0]       o_sent_cnt,
   output logic [31:0]       o_rcv_cnt,
   output logic [31:0]       o_err_cnt,
   output logic [47:0]       o_lat_sum,
   output logic [DW-1:0]     o_lat_max
);

   localparam int          FW       = flit_width(DW, AW);
   localparam int          DEST_LSB = flit_dest_lsb(DW);
   localparam int          HEAD_BIT = flit_head_bit(DW, AW);
   localparam logic [AW-1:0] ADDR   = AW'(ADDRESS);
   localparam logic [15:0] SEED_MIX = SEED ^ 16'(ADDRESS);
   localparam logic [15:0] SEED_EFF = (SEED_MIX == 16'h0000) ? 16'h0001 : SEED_MIX;

   state_e          state, state_nx;
   logic [DW-1:0]   ts;
   logic [15:0]     lfsr;
   pattern_e        pattern_q, eff_pat;
   logic [7:0]      rate_q, eff_rate;
   logic            valid;
   logic [FW-1:0]   flit;
   logic [31:0]     sent_cnt;
   logic            done;
   logic [AW-1:0]   dest;
   logic            accept, pending, hit_limit, win, launch;
   logic            start_ok, try_inj, finish;
   logic [DW-1:0]   latency;
   logic            unused_rx;

   assign accept    = valid && i_data_ready;
   assign pending   = valid && !accept;
   assign hit_limit = (PKT_LIMIT != 0) && accept && (sent_cnt + 32'd1 == 32'(PKT_LIMIT));
   assign eff_pat   = start_ok ? pattern_e'(i_pattern) : pattern_q;
   assign eff_rate  = start_ok ? i_rate : rate_q;
   assign win       = (eff_rate == 8'hFF) || (lfsr[7:0] < eff_rate);
   assign launch    = try_inj && win;
   assign latency   = ts - i_data[DW-1:0];
   assign unused_rx = ^{i_data[HEAD_BIT -: 2], i_data[DW]};

   pe_tg_dest #(.NUM_PE(NUM_PE), .AW(AW)) u_dest (
      .pattern (eff_pat),
      .address (ADDR),
      .rnd     (lfsr[15:16-AW]),
      .dest    (dest)
   );

   // Next state plus injection eligibility; a start launches in the same cycle
   always_comb begin
      state_nx = state;
      start_ok = 1'b0;
      try_inj  = 1'b0;
      finish   = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               start_ok = 1'b1;
               try_inj  = 1'b1;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            if (hit_limit || (i_stop && !pending)) begin
               finish   = 1'b1;
               state_nx = ST_DONE;
            end else if (!pending && !i_stop) begin
               try_inj  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Free-running timestamp counter
   always_ff @(posedge clk) begin
      if (rst) ts <= '0;
      else     ts <= ts + DW'(1);
   end

   // Injection LFSR advances only while it is being consulted
   always_ff @(posedge clk) begin
      if (rst)          lfsr <= SEED_EFF;
      else if (try_inj) lfsr <= lfsr_next(lfsr);
   end

   // Run configuration tracks the inputs until a run is in progress
   always_ff @(posedge clk) begin
      if (state != ST_RUN) begin
         pattern_q <= pattern_e'(i_pattern);
         rate_q    <= i_rate;
      end
   end

   // Output flit register: holds until accepted, reloads on the accept cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         flit  <= '0;
      end else if (launch) begin
         valid <= 1'b1;
         flit  <= {2'b11, dest, 1'b0, ts};
      end else if (accept) begin
         valid <= 1'b0;
      end
   end

   // Per-run sent counter and sticky completion flag
   always_ff @(posedge clk) begin
      if (rst) begin
         sent_cnt <= '0;
         done     <= 1'b0;
      end else begin
         if (start_ok)    sent_cnt <= '0;
         else if (accept) sent_cnt <= sent_cnt + 32'd1;
         if (start_ok)    done <= 1'b0;
         else if (finish) done <= 1'b1;
      end
   end

   // Receive statistics, cumulative across runs
   always_ff @(posedge clk) begin
      if (rst) begin
         o_rcv_cnt <= '0;
         o_err_cnt <= '0;
         o_lat_sum <= '0;
         o_lat_max <= '0;
      end else if (i_data_valid) begin
         o_rcv_cnt <= o_rcv_cnt + 32'd1;
         o_lat_sum <= o_lat_sum + 48'(latency);
         if (latency > o_lat_max) o_lat_max <= latency;
         if (i_data[DEST_LSB +: AW] != ADDR) o_err_cnt <= o_err_cnt + 32'd1;
      end
   end

   assign o_data       = flit;
   assign o_data_valid = valid;
   assign o_data_ready = 1'b1;
   assign o_busy       = (state == ST_RUN);
   assign o_done       = done;
   assign o_sent_cnt   = sent_cnt;

endmodule
